// File: rtl/data_memory.sv
// rtl/data_memory.sv - 128-bit single-port pixel data memory with registered read (optional DATA_MEMORY_PARITY_EN)
//
// Storage sits between the pixel loader and the histogram accumulator.
// Each word packs DATA_W/8 pixel bytes; byte k lives at bits [8k+7:8k].
// Reads are registered (one-cycle latency) and write-first: a write edge
// also loads the written data into rd.
// Reset clears only the output registers; stored words survive rst.
// Defining DATA_MEMORY_PARITY_EN adds one even-parity bit per byte and a
// registered par_err flag that is reported alongside rd.

module data_memory #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              wrclk,
   input  logic              rst,
   input  logic              wd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
`ifdef DATA_MEMORY_PARITY_EN
   output logic              par_err,
`endif
   output logic [DATA_W-1:0] rd
);

   localparam int NBYTES = DATA_W / 8;

   // Word storage; powers up all-zero and is never cleared by rst.
   logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic              in_range;
   logic [DATA_W-1:0] rd_next;

   // When DEPTH fills the address space every address is legal; otherwise
   // addresses at or above DEPTH are treated as holes (no write, read 0).
   if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
   end else begin : g_part_range
      assign in_range = ({1'b0, addr} < DEPTH[ADDR_W:0]);
   end

`ifdef DATA_MEMORY_PARITY_EN
   // One even-parity bit per byte, captured at write time.
   logic [NBYTES-1:0] par_mem [0:DEPTH-1] = '{default: '0};
   logic              par_err_next;

   // Per-byte even parity: bit k makes byte k plus the bit an even count of ones.
   function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_W-1:0] w);
      logic [NBYTES-1:0] p;
      p = '0;
      for (int k = 0; k < NBYTES; k++) begin
         p[k] = ^w[8*k +: 8];
      end
      return p;
   endfunction

   // Next read value and parity check; write-first reads bypass the array
   // and therefore can never report a parity error.
   always_comb begin
      rd_next      = '0;
      par_err_next = 1'b0;
      if (in_range) begin
         if (wd) begin
            rd_next = data;
         end else begin
            rd_next      = mem[addr];
            par_err_next = |(byte_parity(mem[addr]) ^ par_mem[addr]);
         end
      end
   end

   // Array and parity write port; a write presented together with rst is dropped.
   always_ff @(posedge wrclk) begin
      if (!rst && wd && in_range) begin
         mem[addr]     <= data;
         par_mem[addr] <= byte_parity(data);
      end
   end

   // Registered read data and parity flag; rst clears both.
   always_ff @(posedge wrclk) begin
      if (rst) begin
         rd      <= '0;
         par_err <= 1'b0;
      end else begin
         rd      <= rd_next;
         par_err <= par_err_next;
      end
   end
`else
   // Next read value: write data on a write edge, stored word otherwise.
   always_comb begin
      rd_next = '0;
      if (in_range) begin
         rd_next = wd ? data : mem[addr];
      end
   end

   // Array write port; a write presented together with rst is dropped.
   always_ff @(posedge wrclk) begin
      if (!rst && wd && in_range) begin
         mem[addr] <= data;
      end
   end

   // Registered read data; rst clears the output only.
   always_ff @(posedge wrclk) begin
      if (rst) begin
         rd <= '0;
      end else begin
         rd <= rd_next;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory (parity checks under DATA_MEMORY_PARITY_EN)

module tb_data_memory;

   localparam int DATA_W = 128;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              wrclk;
   logic              rst;
   logic              wd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] rd;
`ifdef DATA_MEMORY_PARITY_EN
   logic              par_err;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: plain array of words plus the expected outputs.
   logic [DATA_W-1:0] mem_m [0:DEPTH-1];
   logic [DATA_W-1:0] exp_rd;
   logic              exp_par;

   data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .wrclk (wrclk),
      .rst   (rst),
      .wd    (wd),
      .addr  (addr),
      .data  (data),
`ifdef DATA_MEMORY_PARITY_EN
      .par_err (par_err),
`endif
      .rd    (rd)
   );

   initial wrclk = 1'b0;
   always #5 wrclk = ~wrclk;

   task automatic check_rd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: rd observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Apply one cycle of inputs (called at a falling edge), advance the model by
   // the rules of the memory, then compare outputs at the next falling edge.
   task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input string tag);
      rst  = r;
      wd   = w;
      addr = a;
      data = d;
      exp_par = 1'b0;
      if (r) begin
         exp_rd = '0;
      end else if (w) begin
         mem_m[a] = d;
         exp_rd   = d;
      end else begin
         exp_rd = mem_m[a];
      end
      @(negedge wrclk);
      check_rd(tag, rd, exp_rd);
`ifdef DATA_MEMORY_PARITY_EN
      check_bit({tag, "_par"}, par_err, exp_par);
`endif
   endtask

   logic [DATA_W-1:0] ones;
   logic [DATA_W-1:0] v;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      ones = '1;
      rst  = 1'b1;
      wd   = 1'b0;
      addr = '0;
      data = '0;

      // Reset with a write pending: write is suppressed, rd is 0.
      step(1'b1, 1'b1, 8'd0, ones, "rst_cyc0");
      step(1'b1, 1'b1, 8'd0, ones, "rst_cyc1");
      step(1'b0, 1'b0, 8'd0, '0,   "rst_read0");

      // Write then read; write-first shows data right after the write edge.
      v = 128'hffffffffffffffff0000000000000000;
      step(1'b0, 1'b1, 8'd3, v,  "wr3_first");
      step(1'b0, 1'b0, 8'd3, '0, "rd3");

      v = 128'h7e7e7e7e7e7e7d7d7d7b7b7b7a7a7a7a;
      step(1'b0, 1'b1, 8'd5, v,  "wr5_first");
      step(1'b0, 1'b0, 8'd5, '0, "rd5");

      // Independence of addr 0 and DEPTH-1, retention across reset.
      step(1'b0, 1'b1, 8'd0,   128'h1, "wr0");
      step(1'b0, 1'b1, 8'd255, 128'h2, "wr255");
      step(1'b1, 1'b0, 8'd0,   '0,     "rst_mid");
      step(1'b0, 1'b0, 8'd0,   '0,     "ret0");
      step(1'b0, 1'b0, 8'd255, '0,     "ret255");
      step(1'b0, 1'b0, 8'd5,   '0,     "ret5");

      // Hold: constant read address while data toggles.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 8'd3, {$urandom, $urandom, $urandom, $urandom}, "hold3");
      end

      // Randomized traffic on a small address window plus the top word.
      for (int i = 0; i < 400; i++) begin
         logic r, w;
         logic [ADDR_W-1:0] a;
         r = ($urandom_range(0, 15) == 0);
         w = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
         step(r, w, a, {$urandom, $urandom, $urandom, $urandom}, "rand");
      end

`ifdef DATA_MEMORY_PARITY_EN
      // Parity: clean word reads par_err 0, a flipped stored bit reads par_err 1.
      v = {16{8'h81}};
      step(1'b0, 1'b1, 8'd7, v,  "par_wr7");
      step(1'b0, 1'b0, 8'd7, '0, "par_rd7_clean");
      dut.mem[7][0] = ~dut.mem[7][0];
      mem_m[7][0]   = ~mem_m[7][0];
      rst = 1'b0; wd = 1'b0; addr = 8'd7; data = '0;
      @(negedge wrclk);
      check_rd("par_rd7_flip", rd, mem_m[7]);
      check_bit("par_err_flip", par_err, 1'b1);
      step(1'b0, 1'b0, 8'd3, '0, "par_rd3_clean");
      step(1'b1, 1'b0, 8'd7, '0, "par_rst");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
